// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch into a 2-entry {pc, instr} buffer with IDLE/RUN/DRAIN/DONE control; FETCH_STALL_COUNT_EN adds a full-buffer stall counter
module fetch_stage #(
  parameter int IW = 9,
  parameter int AW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] PcIn,
  output logic          PcAdvance,
  output logic [AW-1:0] ImemAddr,
  input  logic [IW-1:0] ImemData,
  input  logic          Flush,
  output logic          InstrValid,
  output logic [IW-1:0] InstrOut,
  output logic [AW-1:0] PcOut,
  input  logic          DecodeReady,
  output logic          Done,
  output logic [15:0]   StallCount
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
  state_t state, state_nxt;
  logic [1:0] count, count_nxt;
  logic [AW+IW-1:0] e0, e1, entry;
  logic push, pop, start_acc;
  assign entry = {PcIn, ImemData};
  // Buffer handshakes and next state; Flush overrides every other event
  always_comb begin
    start_acc = Start && (state == ST_IDLE || state == ST_DONE);
    push = state == ST_RUN && count != 2'd2 && !Flush;
    pop = count != 2'd0 && DecodeReady && !Flush;
    count_nxt = Flush ? 2'd0 : count + 2'(push) - 2'(pop);
    state_nxt = start_acc ? ST_RUN :
                (state == ST_RUN && push && &ImemData) ? ST_DRAIN :
                state != ST_DRAIN ? state :
                Flush ? ST_RUN :
                count_nxt == 2'd0 ? ST_DONE : ST_DRAIN;
  end
  // State register
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= ST_IDLE;
    else state <= state_nxt;
  // Shift-style buffer: e0 is always the head, e1 the second entry
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      count <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      count <= count_nxt;
      if (push && (count == 2'd0 || pop)) e0 <= entry;
      else if (pop && count == 2'd2) e0 <= e1;
      if (push && count == 2'd1 && !pop) e1 <= entry;
    end
  assign PcAdvance = push;
  assign ImemAddr = PcIn;
  assign InstrValid = count != 2'd0;
  assign {PcOut, InstrOut} = e0;
  assign Done = state == ST_DONE;
`ifdef FETCH_STALL_COUNT_EN
  logic [15:0] stall;
  // Saturating count of RUN cycles that begin with a full buffer, cleared by an accepted Start
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) stall <= 16'd0;
    else if (start_acc) stall <= 16'd0;
    else if (state == ST_RUN && count == 2'd2 && stall != 16'hFFFF) stall <= stall + 16'd1;
  assign StallCount = stall;
`else
  assign StallCount = 16'd0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table, corner sequences and random traffic against a queue-based model of fetch_stage
module tb_fetch_stage;
  localparam int IW = 9;
  localparam int AW = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
  logic Clk = 0, Reset = 0, Start = 0, Flush = 0, DecodeReady = 0;
  logic [AW-1:0] PcIn = '0;
  logic PcAdvance, InstrValid, Done;
  logic [AW-1:0] ImemAddr, PcOut;
  logic [IW-1:0] ImemData, InstrOut;
  logic [15:0] StallCount;
  logic [IW-1:0] rom [256];
  logic [16:0] q [$];
  int mode = M_IDLE;
  int stall = 0;
  int n_cmp = 0, n_bad = 0;

  fetch_stage #(.IW(IW), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .PcIn(PcIn), .PcAdvance(PcAdvance),
    .ImemAddr(ImemAddr), .ImemData(ImemData), .Flush(Flush), .InstrValid(InstrValid),
    .InstrOut(InstrOut), .PcOut(PcOut), .DecodeReady(DecodeReady), .Done(Done),
    .StallCount(StallCount)
  );

  assign ImemData = rom[ImemAddr];
  always #5 Clk = ~Clk;

  typedef struct {
    bit s;
    bit dr;
    bit adv;
    bit v;
    logic [8:0] ins;
    logic [7:0] pc;
    logic [7:0] addr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_stall();
`ifdef FETCH_STALL_COUNT_EN
    return 16'(stall);
`else
    return 16'd0;
`endif
  endfunction

  task automatic model_chk();
    bit adv;
    adv = mode == M_RUN && q.size() < 2 && !Flush;
    chk("adv", 32'(PcAdvance), 32'(adv));
    chk("addr", 32'(ImemAddr), 32'(PcIn));
    chk("valid", 32'(InstrValid), 32'(q.size() != 0));
    if (q.size() != 0) chk("head", 32'({PcOut, InstrOut}), 32'(q[0]));
    chk("done", 32'(Done), 32'(mode == M_DONE));
    chk("stall", 32'(StallCount), 32'(exp_stall()));
  endtask

  task automatic model_step();
    int n;
    bit adv, pop;
    n = q.size();
    adv = mode == M_RUN && n < 2 && !Flush;
    pop = n > 0 && DecodeReady && !Flush;
    if (Flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (adv) q.push_back({PcIn, rom[PcIn]});
    end
    if ((mode == M_IDLE || mode == M_DONE) && Start) stall = 0;
    else if (mode == M_RUN && n == 2 && stall < 65535) stall++;
    case (mode)
      M_IDLE: if (Start) mode = M_RUN;
      M_RUN: if (adv && rom[PcIn] == 9'h1FF) mode = M_DRAIN;
      M_DRAIN: if (Flush) mode = M_RUN; else if (q.size() == 0) mode = M_DONE;
      default: if (Start) mode = M_RUN;
    endcase
  endtask

  task automatic pre(input bit s, input bit fl, input bit dr);
    Start = s;
    Flush = fl;
    DecodeReady = dr;
    @(negedge Clk);
    model_chk();
  endtask

  task automatic post();
    bit adv;
    adv = mode == M_RUN && q.size() < 2 && !Flush;
    model_step();
    @(posedge Clk);
    #1;
    if (adv) PcIn = PcIn + 8'd1;
    Start = 0;
    Flush = 0;
  endtask

  task automatic cyc(input bit s, input bit fl, input bit dr);
    pre(s, fl, dr);
    post();
  endtask

  task automatic do_reset();
    Reset = 0;
    Start = 0;
    Flush = 0;
    q.delete();
    mode = M_IDLE;
    stall = 0;
    #1;
    chk("rst_valid", 32'(InstrValid), 0);
    chk("rst_instr", 32'(InstrOut), 0);
    chk("rst_pc", 32'(PcOut), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_stall", 32'(StallCount), 0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1;
  endtask

  initial begin
    vec_t tbl [6];
    tbl[0] = '{1, 1, 0, 0, 9'h000, 8'h00, 8'h00};
    tbl[1] = '{0, 1, 1, 0, 9'h000, 8'h00, 8'h00};
    tbl[2] = '{0, 1, 1, 1, 9'h001, 8'h00, 8'h01};
    tbl[3] = '{0, 1, 1, 1, 9'h002, 8'h01, 8'h02};
    tbl[4] = '{0, 1, 1, 1, 9'h003, 8'h02, 8'h03};
    tbl[5] = '{0, 1, 1, 1, 9'h004, 8'h03, 8'h04};
    for (int i = 0; i < 256; i++) rom[i] = 9'h0AA;
    for (int i = 0; i < 5; i++) rom[i] = 9'(i + 1);
    rom[5] = 9'h1FF;

    do_reset();
    PcIn = 8'h00;
    for (int i = 0; i < 6; i++) begin
      pre(tbl[i].s, 0, tbl[i].dr);
      chk("tbl_adv", 32'(PcAdvance), 32'(tbl[i].adv));
      chk("tbl_addr", 32'(ImemAddr), 32'(tbl[i].addr));
      chk("tbl_valid", 32'(InstrValid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk("tbl_instr", 32'(InstrOut), 32'(tbl[i].ins));
        chk("tbl_pcout", 32'(PcOut), 32'(tbl[i].pc));
      end
      post();
    end

    do_reset();
    PcIn = 8'h00;
    cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    pre(0, 0, 0);
    chk("full_adv", 32'(PcAdvance), 0);
    chk("full_instr", 32'(InstrOut), 32'h001);
    chk("full_pcout", 32'(PcOut), 0);
`ifdef FETCH_STALL_COUNT_EN
    chk("full_stall", 32'(StallCount), 2);
`endif
    post();
    PcIn = 8'h40;
    pre(0, 1, 1);
    chk("flush_adv", 32'(PcAdvance), 0);
    post();
    pre(0, 0, 1);
    chk("flush_valid", 32'(InstrValid), 0);
    chk("flush_resume", 32'(PcAdvance), 1);
    chk("flush_addr", 32'(ImemAddr), 32'h40);
    post();
    pre(0, 0, 1);
    chk("flush_head", 32'({PcOut, InstrOut}), 32'({8'h40, 9'h0AA}));
    post();

    do_reset();
    PcIn = 8'h00;
    cyc(1, 0, 1);
    repeat (5) cyc(0, 0, 1);
    pre(0, 0, 1);
    chk("halt_cap", 32'(PcAdvance), 1);
    chk("halt_addr", 32'(ImemAddr), 5);
    post();
    pre(0, 0, 1);
    chk("halt_adv", 32'(PcAdvance), 0);
    chk("halt_valid", 32'(InstrValid), 1);
    chk("halt_instr", 32'(InstrOut), 32'h1FF);
    chk("halt_pcout", 32'(PcOut), 5);
    chk("halt_notdone", 32'(Done), 0);
    post();
    pre(0, 0, 1);
    chk("halt_done", 32'(Done), 1);
    chk("halt_noadv", 32'(PcAdvance), 0);
    post();
    pre(0, 0, 1);
    chk("done_hold", 32'(Done), 1);
    chk("done_noadv", 32'(PcAdvance), 0);
    post();
    cyc(1, 0, 1);
    pre(0, 0, 1);
    chk("restart_adv", 32'(PcAdvance), 1);
    chk("restart_done", 32'(Done), 0);
    post();

    do_reset();
    PcIn = 8'h10;
    cyc(1, 0, 1);
    repeat (3) cyc(0, 0, 0);
    chk("pre_rst_valid", 32'(InstrValid), 1);
    Reset = 0;
    #1;
    chk("mid_rst_valid", 32'(InstrValid), 0);
    chk("mid_rst_instr", 32'(InstrOut), 0);
    chk("mid_rst_adv", 32'(PcAdvance), 0);
    q.delete();
    mode = M_IDLE;
    stall = 0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1;
    repeat (3) begin
      pre(0, 0, 1);
      chk("wait_start", 32'(PcAdvance), 0);
      post();
    end
    cyc(1, 0, 1);
    pre(0, 0, 1);
    chk("resume_adv", 32'(PcAdvance), 1);
    post();

    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 15) == 0) ? 9'h1FF : 9'($urandom);
    do_reset();
    PcIn = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      bit s, fl, dr;
      s = $urandom_range(0, 11) == 0;
      fl = $urandom_range(0, 9) == 0;
      dr = $urandom_range(0, 2) != 0;
      if (fl) PcIn = 8'($urandom);
      cyc(s, fl, dr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
